width_conv_fifo: RTL and testbench

WIDTH_CONV_FIFO -- requirements
Module: width_conv_fifo

---
 rtl/width_conv_fifo.sv | 149 ++++++++++++++
 tb/tb_width_conv_fifo.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/width_conv_fifo.sv
// Single-clock FIFO with power-of-two width conversion between write and read ports.
// Storage, pointers and occupancy are all kept in units of the narrower port width.
module width_conv_fifo #(
   parameter int DATA_W  = 64,
   parameter int DATA_R  = 16,
   parameter int DEPTH_W = 9,
   parameter int FWFT    = 0,
   localparam int U       = (DATA_W < DATA_R) ? DATA_W : DATA_R,
   localparam int WU      = DATA_W / U,
   localparam int RU      = DATA_R / U,
   localparam int LOG_WU  = $clog2(WU),
   localparam int LOG_RU  = $clog2(RU),
   localparam int DEPTH_R = DEPTH_W + LOG_WU - LOG_RU
) (
   input  logic              system_clk,
   input  logic              rst_n,
   input  logic              i_flush,
   input  logic              i_clr_err,
   input  logic              i_wren,
   input  logic [DATA_W-1:0] i_wrdata,
   input  logic              i_rden,
   output logic [DATA_R-1:0] o_rddata,
   output logic              o_full,
   output logic              o_empty,
   input  logic [DEPTH_W:0]  i_afull_thr,
   input  logic [DEPTH_R:0]  i_aempty_thr,
   output logic              o_almost_full,
   output logic              o_almost_empty,
   output logic [DEPTH_W:0]  o_wr_count,
   output logic [DEPTH_R:0]  o_rd_count,
   output logic              o_overflow,
   output logic              o_underflow
);

   localparam int PTR_W = DEPTH_W + LOG_WU;
   localparam int TOTAL = 1 << PTR_W;
   localparam int RATIO = (WU > RU) ? WU : RU;
   localparam bit LEGAL = ((DATA_W % DATA_R == 0) || (DATA_R % DATA_W == 0)) &&
                          ((RATIO & (RATIO - 1)) == 0) && (DEPTH_R >= 0) && (DEPTH_W >= 0);

   localparam logic [PTR_W:0] TOTAL_C = (PTR_W+1)'(TOTAL);
   localparam logic [PTR_W:0] WU_C    = (PTR_W+1)'(WU);
   localparam logic [PTR_W:0] RU_C    = (PTR_W+1)'(RU);

   generate
      if (!LEGAL) begin : g_bad_params
         $fatal(1, "width_conv_fifo: illegal DATA_W/DATA_R/DEPTH_W combination");
      end
   endgenerate

   logic [U-1:0]      mem_r [TOTAL];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [PTR_W:0]    count_r;
   logic [PTR_W:0]    count_nxt_s;
   logic [DATA_R-1:0] rddata_r;
   logic [DATA_R-1:0] head_s;
   logic              overflow_r;
   logic              underflow_r;
   logic              full_s;
   logic              empty_s;
   logic              wr_acc_s;
   logic              rd_acc_s;
   logic              ovf_set_s;
   logic              unf_set_s;

   // Flags come straight from the registered count; no look-ahead.
   assign full_s    = (TOTAL_C - count_r) < WU_C;
   assign empty_s   = count_r < RU_C;
   assign wr_acc_s  = i_wren & ~full_s & ~i_flush;
   assign rd_acc_s  = i_rden & ~empty_s & ~i_flush;
   assign ovf_set_s = i_wren & full_s & ~i_flush;
   assign unf_set_s = i_rden & empty_s & ~i_flush;

   assign count_nxt_s = count_r + (wr_acc_s ? WU_C : '0) - (rd_acc_s ? RU_C : '0);

   // Assemble the head read word, lowest address in the least significant lane.
   always_comb begin
      head_s = '0;
      for (int k = 0; k < RU; k++) begin
         head_s[k*U +: U] = mem_r[rd_ptr_r + PTR_W'(k)];
      end
   end

   // Storage write; contents are deliberately left untouched by reset.
   always_ff @(posedge system_clk) begin
      if (rst_n && wr_acc_s) begin
         for (int k = 0; k < WU; k++) begin
            mem_r[wr_ptr_r + PTR_W'(k)] <= i_wrdata[k*U +: U];
         end
      end
   end

   // Pointer and occupancy tracking; pointers wrap naturally at TOTAL.
   always_ff @(posedge system_clk) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else if (i_flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (wr_acc_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(WU);
         end
         if (rd_acc_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(RU);
         end
         count_r <= count_nxt_s;
      end
   end

   // Sticky error flags; a new error in the clearing cycle takes priority.
   always_ff @(posedge system_clk) begin
      if (!rst_n) begin
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         overflow_r  <= ovf_set_s | (overflow_r & ~i_clr_err);
         underflow_r <= unf_set_s | (underflow_r & ~i_clr_err);
      end
   end

   // Read data register: popped word in normal mode, last visible head in FWFT mode.
   always_ff @(posedge system_clk) begin
      if (!rst_n) begin
         rddata_r <= '0;
      end else if (FWFT != 0) begin
         if (!empty_s) begin
            rddata_r <= head_s;
         end
      end else if (rd_acc_s) begin
         rddata_r <= head_s;
      end
   end

   assign o_rddata       = ((FWFT != 0) && !empty_s) ? head_s : rddata_r;
   assign o_full         = full_s;
   assign o_empty        = empty_s;
   assign o_wr_count     = count_r[PTR_W:LOG_WU];
   assign o_rd_count     = count_r[PTR_W:LOG_RU];
   assign o_almost_full  = o_wr_count >= i_afull_thr;
   assign o_almost_empty = o_rd_count < i_aempty_thr;
   assign o_overflow     = overflow_r;
   assign o_underflow    = underflow_r;

endmodule

// File: tb/tb_width_conv_fifo.sv
// Self-checking bench: 64->16 (normal and FWFT) and 16->64 instances of width_conv_fifo,
// a vector table for the main flag/count behaviour, and a data scoreboard.
module tb_width_conv_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        clr_err = 1'b0;
   logic        wren = 1'b0;
   logic        rden = 1'b0;
   logic [63:0] wrdata = 64'd0;
   logic [2:0]  afull_thr = 3'd3;
   logic [4:0]  aempty_thr = 5'd2;

   logic [15:0] a_rddata, c_rddata;
   logic        a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
   logic        c_full, c_empty, c_af, c_ae, c_ovf, c_unf;
   logic [2:0]  a_wrc, c_wrc;
   logic [4:0]  a_rdc, c_rdc;

   logic        b_wren = 1'b0;
   logic        b_rden = 1'b0;
   logic [15:0] b_wrdata = 16'd0;
   logic [2:0]  b_afull_thr = 3'd3;
   logic [0:0]  b_aempty_thr = 1'b1;
   logic [63:0] b_rddata;
   logic        b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
   logic [2:0]  b_wrc;
   logic [0:0]  b_rdc;

   width_conv_fifo #(.DATA_W(64), .DATA_R(16), .DEPTH_W(2), .FWFT(0)) dut_a (
      .system_clk(clk), .rst_n(rst_n), .i_flush(flush), .i_clr_err(clr_err),
      .i_wren(wren), .i_wrdata(wrdata), .i_rden(rden), .o_rddata(a_rddata),
      .o_full(a_full), .o_empty(a_empty), .i_afull_thr(afull_thr), .i_aempty_thr(aempty_thr),
      .o_almost_full(a_af), .o_almost_empty(a_ae), .o_wr_count(a_wrc), .o_rd_count(a_rdc),
      .o_overflow(a_ovf), .o_underflow(a_unf));

   width_conv_fifo #(.DATA_W(64), .DATA_R(16), .DEPTH_W(2), .FWFT(1)) dut_c (
      .system_clk(clk), .rst_n(rst_n), .i_flush(flush), .i_clr_err(clr_err),
      .i_wren(wren), .i_wrdata(wrdata), .i_rden(rden), .o_rddata(c_rddata),
      .o_full(c_full), .o_empty(c_empty), .i_afull_thr(afull_thr), .i_aempty_thr(aempty_thr),
      .o_almost_full(c_af), .o_almost_empty(c_ae), .o_wr_count(c_wrc), .o_rd_count(c_rdc),
      .o_overflow(c_ovf), .o_underflow(c_unf));

   width_conv_fifo #(.DATA_W(16), .DATA_R(64), .DEPTH_W(2), .FWFT(0)) dut_b (
      .system_clk(clk), .rst_n(rst_n), .i_flush(flush), .i_clr_err(clr_err),
      .i_wren(b_wren), .i_wrdata(b_wrdata), .i_rden(b_rden), .o_rddata(b_rddata),
      .o_full(b_full), .o_empty(b_empty), .i_afull_thr(b_afull_thr), .i_aempty_thr(b_aempty_thr),
      .o_almost_full(b_af), .o_almost_empty(b_ae), .o_wr_count(b_wrc), .o_rd_count(b_rdc),
      .o_overflow(b_ovf), .o_underflow(b_unf));

   typedef struct {
      bit          wr;
      logic [63:0] d;
      bit          rd;
      bit          clr;
      int          cnt;   // expected occupancy in 16-bit units after the edge
      bit          ovf;
      bit          unf;
   } vec_t;

   localparam int NV = 20;
   vec_t        tbl [NV];
   logic [15:0] q [$];
   int          m_cnt = 0;
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; wren = 1'b0; rden = 1'b0; flush = 1'b0; clr_err = 1'b0;
      b_wren = 1'b0; b_rden = 1'b0;
      tick();
      rst_n = 1'b1;
      q.delete();
      m_cnt = 0;
   endtask

   function automatic logic [63:0] w(input int n);
      logic [63:0] r;
      for (int k = 0; k < 4; k++) r[k*16 +: 16] = 16'((n << 8) | (k + 1));
      return r;
   endfunction

   function automatic vec_t mk(input bit wr_i, input logic [63:0] d_i, input bit rd_i,
                               input bit clr_i, input int cnt_i, input bit ovf_i, input bit unf_i);
      vec_t v;
      v.wr = wr_i; v.d = d_i; v.rd = rd_i; v.clr = clr_i;
      v.cnt = cnt_i; v.ovf = ovf_i; v.unf = unf_i;
      return v;
   endfunction

   task automatic wr_a(input logic [63:0] d);
      wren = 1'b1; wrdata = d;
      for (int k = 0; k < 4; k++) q.push_back(d[k*16 +: 16]);
      tick();
      wren = 1'b0;
   endtask

   task automatic rd_a(input string nm);
      logic [15:0] e;
      rden = 1'b1;
      e = q.pop_front();
      tick();
      rden = 1'b0;
      chk(nm, {48'd0, a_rddata}, {48'd0, e});
   endtask

   initial begin
      logic [15:0] exp_d;
      logic [15:0] last;
      bit          wr_ok, rd_ok;

      tbl[0]  = mk(1'b1, 64'h4444_3333_2222_1111, 1'b0, 1'b0, 4, 1'b0, 1'b0);
      tbl[1]  = mk(1'b0, 64'd0, 1'b1, 1'b0, 3, 1'b0, 1'b0);
      tbl[2]  = mk(1'b0, 64'd0, 1'b1, 1'b0, 2, 1'b0, 1'b0);
      tbl[3]  = mk(1'b0, 64'd0, 1'b1, 1'b0, 1, 1'b0, 1'b0);
      tbl[4]  = mk(1'b0, 64'd0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      tbl[5]  = mk(1'b0, 64'd0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
      tbl[6]  = mk(1'b0, 64'd0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      tbl[7]  = mk(1'b1, w(1), 1'b0, 1'b0, 4, 1'b0, 1'b0);
      tbl[8]  = mk(1'b1, w(2), 1'b0, 1'b0, 8, 1'b0, 1'b0);
      tbl[9]  = mk(1'b1, w(3), 1'b0, 1'b0, 12, 1'b0, 1'b0);
      tbl[10] = mk(1'b1, w(4), 1'b0, 1'b0, 16, 1'b0, 1'b0);
      tbl[11] = mk(1'b1, w(5), 1'b0, 1'b0, 16, 1'b1, 1'b0);
      tbl[12] = mk(1'b1, w(6), 1'b1, 1'b0, 15, 1'b1, 1'b0);
      tbl[13] = mk(1'b1, w(6), 1'b1, 1'b0, 14, 1'b1, 1'b0);
      tbl[14] = mk(1'b0, 64'd0, 1'b0, 1'b1, 14, 1'b0, 1'b0);
      tbl[15] = mk(1'b0, 64'd0, 1'b1, 1'b0, 13, 1'b0, 1'b0);
      tbl[16] = mk(1'b0, 64'd0, 1'b1, 1'b0, 12, 1'b0, 1'b0);
      tbl[17] = mk(1'b1, w(7), 1'b1, 1'b0, 15, 1'b0, 1'b0);
      tbl[18] = mk(1'b1, w(8), 1'b0, 1'b1, 15, 1'b1, 1'b0);
      tbl[19] = mk(1'b0, 64'd0, 1'b0, 1'b1, 15, 1'b0, 1'b0);

      // reset state
      do_reset();
      chk("rst_empty", a_empty, 1'b1);
      chk("rst_full", a_full, 1'b0);
      chk("rst_wrc", a_wrc, 3'd0);
      chk("rst_rdc", a_rdc, 5'd0);
      chk("rst_ae", a_ae, 1'b1);
      chk("rst_af", a_af, 1'b0);
      chk("rst_ovf", a_ovf, 1'b0);
      chk("rst_unf", a_unf, 1'b0);
      chk("rst_rddata", a_rddata, 16'd0);

      // table-driven vectors on the 64->16 instance
      for (int i = 0; i < NV; i++) begin
         wren = tbl[i].wr; wrdata = tbl[i].d; rden = tbl[i].rd; clr_err = tbl[i].clr;
         wr_ok = tbl[i].wr && (16 - m_cnt >= 4);
         rd_ok = tbl[i].rd && (m_cnt >= 1);
         exp_d = 16'd0;
         if (rd_ok) exp_d = q.pop_front();
         if (wr_ok) for (int k = 0; k < 4; k++) q.push_back(tbl[i].d[k*16 +: 16]);
         m_cnt = m_cnt + (wr_ok ? 4 : 0) - (rd_ok ? 1 : 0);
         tick();
         chk($sformatf("v%0d_empty", i), a_empty, (tbl[i].cnt == 0) ? 1'b1 : 1'b0);
         chk($sformatf("v%0d_full", i), a_full, (tbl[i].cnt > 12) ? 1'b1 : 1'b0);
         chk($sformatf("v%0d_wrc", i), a_wrc, 64'(tbl[i].cnt / 4));
         chk($sformatf("v%0d_rdc", i), a_rdc, 64'(tbl[i].cnt));
         chk($sformatf("v%0d_af", i), a_af, (tbl[i].cnt >= 12) ? 1'b1 : 1'b0);
         chk($sformatf("v%0d_ae", i), a_ae, (tbl[i].cnt < 2) ? 1'b1 : 1'b0);
         chk($sformatf("v%0d_ovf", i), a_ovf, tbl[i].ovf);
         chk($sformatf("v%0d_unf", i), a_unf, tbl[i].unf);
         if (rd_ok) chk($sformatf("v%0d_rdata", i), a_rddata, exp_d);
      end
      wren = 1'b0; rden = 1'b0; clr_err = 1'b0;

      // drain the remaining 15 units in order
      for (int i = 0; i < 15; i++) rd_a($sformatf("drain%0d", i));
      chk("drain_empty", a_empty, 1'b1);
      chk("drain_rdc", a_rdc, 5'd0);

      // flush with 3 read words stored, then mid-stream reset
      do_reset();
      wr_a(w(9));
      rd_a("pre_flush_rd");
      chk("pre_flush_rdc", a_rdc, 5'd3);
      flush = 1'b1; wren = 1'b1; wrdata = w(10); rden = 1'b1;
      tick();
      flush = 1'b0; wren = 1'b0; rden = 1'b0;
      q.delete();
      chk("flush_empty", a_empty, 1'b1);
      chk("flush_rdc", a_rdc, 5'd0);
      chk("flush_wrc", a_wrc, 3'd0);
      chk("flush_ovf", a_ovf, 1'b0);
      chk("flush_unf", a_unf, 1'b0);
      chk("flush_rddata", a_rddata, 16'h0901);
      wr_a(w(11));
      for (int i = 0; i < 4; i++) rd_a($sformatf("post_flush%0d", i));
      chk("post_flush_empty", a_empty, 1'b1);
      rden = 1'b1;
      tick();
      rden = 1'b0;
      chk("unf_set", a_unf, 1'b1);
      chk("unf_rddata_hold", a_rddata, 16'h0b04);
      wr_a(w(12));
      rd_a("pre_rst_rd");
      rst_n = 1'b0; wren = 1'b1; wrdata = w(13);
      tick();
      rst_n = 1'b1; wren = 1'b0;
      q.delete();
      chk("mrst_empty", a_empty, 1'b1);
      chk("mrst_rdc", a_rdc, 5'd0);
      chk("mrst_wrc", a_wrc, 3'd0);
      chk("mrst_rddata", a_rddata, 16'd0);
      chk("mrst_unf", a_unf, 1'b0);
      wr_a(w(14));
      for (int i = 0; i < 4; i++) rd_a($sformatf("post_rst%0d", i));
      chk("post_rst_empty", a_empty, 1'b1);

      // 16->64 upsizing
      do_reset();
      for (int i = 0; i < 4; i++) begin
         b_wren = 1'b1; b_wrdata = 16'(16'h1111 * (i + 1));
         tick();
         b_wren = 1'b0;
         chk($sformatf("up_empty%0d", i), b_empty, (i < 3) ? 1'b1 : 1'b0);
      end
      chk("up_full", b_full, 1'b1);
      chk("up_wrc", b_wrc, 3'd4);
      chk("up_rdc", b_rdc, 1'b1);
      chk("up_af", b_af, 1'b1);
      chk("up_ae", b_ae, 1'b0);
      b_rden = 1'b1;
      tick();
      b_rden = 1'b0;
      chk("up_rddata", b_rddata, 64'h4444_3333_2222_1111);
      chk("up_empty_after", b_empty, 1'b1);
      chk("up_full_after", b_full, 1'b0);
      chk("up_ovf", b_ovf, 1'b0);
      chk("up_unf", b_unf, 1'b0);

      // FWFT: 20 write / 4-read rounds, pointers wrap five times
      do_reset();
      last = 16'd0;
      for (int r = 0; r < 20; r++) begin
         wren = 1'b1; wrdata = {$urandom, $urandom};
         for (int k = 0; k < 4; k++) q.push_back(wrdata[k*16 +: 16]);
         tick();
         wren = 1'b0;
         for (int j = 0; j < 4; j++) begin
            chk($sformatf("fwft_r%0d_%0d", r, j), c_rddata, q[0]);
            rden = 1'b1;
            last = q.pop_front();
            tick();
            rden = 1'b0;
         end
      end
      chk("fwft_hold", c_rddata, last);
      chk("fwft_empty", c_empty, 1'b1);
      chk("fwft_full", c_full, 1'b0);
      chk("fwft_wrc", c_wrc, 3'd0);
      chk("fwft_rdc", c_rdc, 5'd0);
      chk("fwft_af", c_af, 1'b0);
      chk("fwft_ae", c_ae, 1'b1);
      chk("fwft_ovf", c_ovf, 1'b0);
      chk("fwft_unf", c_unf, 1'b0);
      rden = 1'b1;
      tick();
      rden = 1'b0;
      chk("fwft_unf_set", c_unf, 1'b1);
      chk("fwft_hold_after_unf", c_rddata, last);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
